// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) serial receiver/checker.
// Searches for alignment by predicting each bit from the last 31 received bits.
// After enough correct predictions in a row it locks and free-runs a local LFSR.
// While locked it counts bit errors against that LFSR.
// Lock is dropped when too many errors land inside one window of valid bits.
module prbs31_checker #(
  parameter int LOCK_MATCHES = 64,
  parameter int WINDOW       = 128,
  parameter int UNLOCK_ERRS  = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [0:0]       ST_SEARCH   = 1'b0;
  localparam logic [0:0]       ST_LOCKED   = 1'b1;
  localparam logic [4:0]       FILL_FULL   = 5'd31;
  localparam logic [7:0]       LOCK_CNT_C  = 8'(LOCK_MATCHES);
  localparam logic [15:0]      WINDOW_C    = 16'(WINDOW);
  localparam logic [15:0]      UNLOCK_C    = 16'(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // Next bit of the PRBS31 sequence given the current 31-bit history.
  function automatic logic prbs_predict(input logic [30:0] hist);
    return hist[27] ^ hist[30];
  endfunction

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return val + CNT_ONE;
    end
  endfunction

  logic [0:0]       state_q, state_d;
  logic [30:0]      s_q, s_d;
  logic [4:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [15:0]      wbits_q, wbits_d;
  logic [15:0]      werrs_q, werrs_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             pred_s;
  logic             err_s;
  logic [15:0]      wbits_inc_s;
  logic [15:0]      werrs_inc_s;

  // Next-state logic for the search/lock FSM, LFSR history, window and error counter.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    wbits_d     = wbits_q;
    werrs_d     = werrs_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    err_s       = 1'b0;
    pred_s      = prbs_predict(s_q);
    wbits_inc_s = wbits_q + 16'd1;
    werrs_inc_s = werrs_q;

    if (din_valid) begin
      case (state_q)
        ST_SEARCH: begin
          // Received bits feed the history so the predictor aligns to the line.
          s_d = {s_q[29:0], din};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 5'd1;
          end else if (din == pred_s) begin
            match_d = match_q + 8'd1;
          end else begin
            match_d = 8'd0;
          end
          // An all-zero history is the LFSR lock-up state and must never lock.
          if (s_d == 31'd0) begin
            match_d = 8'd0;
          end else if (match_d == LOCK_CNT_C) begin
            state_d = ST_LOCKED;
            wbits_d = 16'd0;
            werrs_d = 16'd0;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // Free-run on our own prediction so one line error counts once.
          s_d         = {s_q[29:0], pred_s};
          err_s       = din ^ pred_s;
          err_pulse_d = err_s;
          werrs_inc_s = werrs_q + {15'd0, err_s};
          // Loss-of-lock is judged before the window boundary clears the tally.
          if (err_s && (werrs_inc_s == UNLOCK_C)) begin
            state_d = ST_SEARCH;
            fill_d  = 5'd0;
            match_d = 8'd0;
            wbits_d = 16'd0;
            werrs_d = 16'd0;
          end else if (wbits_inc_s == WINDOW_C) begin
            wbits_d = 16'd0;
            werrs_d = 16'd0;
          end else begin
            wbits_d = wbits_inc_s;
            werrs_d = werrs_inc_s;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          fill_d  = 5'd0;
          match_d = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Clear wins over accumulation but still records an error on the same edge.
    if (clear_cnt) begin
      err_count_d = err_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (err_s) begin
      err_count_d = sat_inc(err_count_q);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_SEARCH;
      s_q         <= 31'd0;
      fill_q      <= 5'd0;
      match_q     <= 8'd0;
      wbits_q     <= 16'd0;
      werrs_q     <= 16'd0;
      err_pulse_q <= 1'b0;
      err_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      wbits_q     <= wbits_d;
      werrs_q     <= werrs_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = state_q[0];
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: a default instance and a CNT_W=4 instance
// share one stimulus stream; the driver pushes the expected outputs of every
// edge and a negedge monitor pops and compares them.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n, din, din_valid, clear_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;

  // Free-running clock, 10 time units period.
  always #5 clk = ~clk;

  prbs31_checker dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs31_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
  );

  typedef struct packed {
    logic        lk;
    logic        pl;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        exp_locked;
  logic [15:0] exp_c16;
  logic [3:0]  exp_c4;
  logic [30:0] g;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference PRBS31 generator: next bit = g[27]^g[30], shifted into g[0].
  task automatic gen_bit(output logic b);
    b = g[27] ^ g[30];
    g = {g[29:0], b};
  endtask

  // Apply one edge of stimulus and queue the outputs expected after it.
  task automatic step(input logic d, input logic v, input logic clr, input logic rst, input logic e);
    exp_t r;
    @(negedge clk);
    din       = d;
    din_valid = v;
    clear_cnt = clr;
    rst_n     = rst;
    @(posedge clk);
    if (rst) begin
      exp_locked = 1'b0;
      exp_c16    = 16'd0;
      exp_c4     = 4'd0;
    end else if (clr) begin
      exp_c16 = {15'd0, e};
      exp_c4  = {3'd0, e};
    end else if (e) begin
      if (exp_c16 != 16'hFFFF) exp_c16 = exp_c16 + 16'd1;
      if (exp_c4 != 4'hF) exp_c4 = exp_c4 + 4'd1;
    end
    r.lk  = exp_locked;
    r.pl  = rst ? 1'b0 : e;
    r.c16 = exp_c16;
    r.c4  = exp_c4;
    sb_q.push_back(r);
  endtask

  // Monitor: compare both instances against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t r;
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      chk("locked",      {15'd0, locked},     {15'd0, r.lk});
      chk("err_pulse",   {15'd0, err_pulse},  {15'd0, r.pl});
      chk("err_count",   err_count,           r.c16);
      chk("locked_w4",   {15'd0, locked4},    {15'd0, r.lk});
      chk("err_pulse_w4",{15'd0, err_pulse4}, {15'd0, r.pl});
      chk("err_count_w4",{12'd0, err_count4}, {12'd0, r.c4});
    end
  end

  initial begin
    logic b;
    int   vcount;
    rst_n      = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    clear_cnt  = 1'b0;
    exp_locked = 1'b0;
    exp_c16    = 16'd0;
    exp_c4     = 4'd0;
    g          = 31'd1;

    // Reset held with random line activity.
    for (int i = 0; i < 2; i++) step(1'($urandom % 2), 1'($urandom % 2), 1'b0, 1'b1, 1'b0);

    // Clean lock: locked rises after bit 95, then 10000 error-free bits.
    for (int n = 1; n <= 95 + 10000; n++) begin
      gen_bit(b);
      exp_locked = (n >= 95);
      step(b, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Single inverted bit: one pulse, count 1, lock held.
    gen_bit(b);
    step(~b, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Loss of lock: relock from reset, 8 errors inside one window, then relock.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 95; n++) begin
      gen_bit(b);
      exp_locked = (n >= 95);
      step(b, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int e = 1; e <= 8; e++) begin
      for (int k = 0; k < 3; k++) begin
        gen_bit(b);
        step(b, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      gen_bit(b);
      exp_locked = (e < 8);
      step(~b, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    for (int n = 1; n <= 95 + 200; n++) begin
      gen_bit(b);
      exp_locked = (n >= 95);
      step(b, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // All-zero stream never locks.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 500; n++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random valid gaps with garbage on din: lock at the 95th valid bit.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vcount = 0;
    while (vcount < 300) begin
      if (($urandom % 2) == 1) begin
        gen_bit(b);
        vcount++;
        exp_locked = (vcount >= 95);
        step(b, 1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        step(1'($urandom % 2), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    // Counter edges: 20 isolated errors saturate the 4-bit counter at 15.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 95; n++) begin
      gen_bit(b);
      exp_locked = (n >= 95);
      step(b, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int e = 0; e < 20; e++) begin
      for (int k = 0; k < 39; k++) begin
        gen_bit(b);
        step(b, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      gen_bit(b);
      step(~b, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    // Clear together with an error leaves a count of 1.
    gen_bit(b);
    step(~b, 1'b1, 1'b1, 1'b0, 1'b1);
    // Clear during a gap cycle returns the count to 0.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
